// File: rtl/ps_cu_issue_pkg.sv
// Shared definitions for the compute-instruction issue stage: instruction field
// layout, class codes, crossbar source encodings and status-register bit map.
package ps_cu_issue_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 4;
    localparam int SRC_W   = 3;

    typedef enum logic [1:0] {
        CLS_NOP = 2'b00,
        CLS_ALU = 2'b01,
        CLS_MUL = 2'b10,
        CLS_SHF = 2'b11
    } instr_class_e;

    localparam int CLS_HI       = 31;
    localparam int CLS_LO       = 30;
    localparam int WADD_LO      = 26;
    localparam int RADDX_LO     = 22;
    localparam int RADDY_LO     = 18;
    localparam int ALU_LOG      = 17;
    localparam int ALU_HC_LO    = 15;
    localparam int ALU_SC_LO    = 12;
    localparam int ALU_SAT      = 11;
    localparam int ALU_CI       = 10;
    localparam int MUL_OTREG    = 17;
    localparam int MUL_DTSTS_LO = 13;
    localparam int MUL_CLS_LO   = 11;
    localparam int MUL_SC_LO    = 9;
    localparam int SHF_CLS_LO   = 16;

    localparam logic [SRC_W-1:0] SRC_ALU = 3'b001;
    localparam logic [SRC_W-1:0] SRC_SHF = 3'b010;
    localparam logic [SRC_W-1:0] SRC_MUL = 3'b100;

    localparam int AST_AZ    = 0;
    localparam int AST_AN    = 1;
    localparam int AST_AC    = 2;
    localparam int AST_AV    = 3;
    localparam int AST_MV    = 4;
    localparam int AST_MN    = 5;
    localparam int AST_SV    = 6;
    localparam int AST_SZ    = 7;
    localparam int AST_COMPD = 8;

    typedef struct packed {
        instr_class_e      cls;
        logic [ADDR_W-1:0] wadd;
        logic [ADDR_W-1:0] raddx;
        logic [ADDR_W-1:0] raddy;
        logic              alu_log;
        logic [1:0]        alu_hc;
        logic [2:0]        alu_sc;
        logic              alu_sat;
        logic              alu_ci;
        logic              mul_otreg;
        logic [3:0]        mul_dtsts;
        logic [1:0]        mul_cls;
        logic [1:0]        mul_sc;
        logic [1:0]        shf_cls;
    } ctrl_t;

    function automatic logic [SRC_W-1:0] src_of(input instr_class_e cls);
        case (cls)
            CLS_ALU: src_of = SRC_ALU;
            CLS_MUL: src_of = SRC_MUL;
            CLS_SHF: src_of = SRC_SHF;
            default: src_of = '0;
        endcase
    endfunction

endpackage

// File: rtl/ps_cu_issue_if.sv
// Fetch-to-issue instruction handshake; the fetch side is the master.
interface ps_cu_issue_if #(
    parameter int INSTR_WIDTH = 32
);

    logic [INSTR_WIDTH-1:0] fe_instr;
    logic                   fe_valid;
    logic                   iss_ready;

    modport master (output fe_instr, output fe_valid, input iss_ready);
    modport slave  (input fe_instr, input fe_valid, output iss_ready);

endinterface

// File: rtl/ps_cu_decode.sv
// Combinational decode of one compute instruction into the compute-unit control
// bundle. Fields that do not belong to the decoded class are driven to zero.
module ps_cu_decode
    import ps_cu_issue_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output ctrl_t              ctrl
);

    instr_class_e cls;
    logic         unused_bits;

    assign cls         = instr_class_e'(instr[CLS_HI:CLS_LO]);
    assign unused_bits = ^instr[MUL_SC_LO-1:0];

    always_comb begin
        ctrl     = '0;
        ctrl.cls = cls;
        // A NOP carries no register addresses so it can never alias a real write.
        if (cls != CLS_NOP) begin
            ctrl.wadd  = instr[WADD_LO  +: ADDR_W];
            ctrl.raddx = instr[RADDX_LO +: ADDR_W];
            ctrl.raddy = instr[RADDY_LO +: ADDR_W];
        end
        case (cls)
            CLS_ALU: begin
                ctrl.alu_log = instr[ALU_LOG];
                ctrl.alu_hc  = instr[ALU_HC_LO +: 2];
                ctrl.alu_sc  = instr[ALU_SC_LO +: 3];
                ctrl.alu_sat = instr[ALU_SAT];
                ctrl.alu_ci  = instr[ALU_CI];
            end
            CLS_MUL: begin
                ctrl.mul_otreg = instr[MUL_OTREG];
                ctrl.mul_dtsts = instr[MUL_DTSTS_LO +: 4];
                ctrl.mul_cls   = instr[MUL_CLS_LO +: 2];
                ctrl.mul_sc    = instr[MUL_SC_LO +: 2];
            end
            CLS_SHF: ctrl.shf_cls = instr[SHF_CLS_LO +: 2];
            default: ;
        endcase
    end

endmodule

// File: rtl/ps_cu_issue.sv
// Compute-instruction issue stage: E/W slot sequencing, read-after-write
// interlock against the E slot, and capture of CU flags into astat.
module ps_cu_issue
    import ps_cu_issue_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int SIGNAL_WIDTH  = 3
) (
    input  logic                     clk_dcd,
    input  logic                     reset,
    input  logic                     stall,
    ps_cu_issue_if.slave             fe,
    output logic                     ps_alu_en,
    output logic                     ps_alu_log,
    output logic                     ps_alu_sat,
    output logic                     ps_alu_ci,
    output logic [1:0]               ps_alu_hc,
    output logic [2:0]               ps_alu_sc,
    output logic                     ps_mul_en,
    output logic                     ps_mul_otreg,
    output logic [3:0]               ps_mul_dtsts,
    output logic [1:0]               ps_mul_cls,
    output logic [1:0]               ps_mul_sc,
    output logic                     ps_shf_en,
    output logic [1:0]               ps_shf_cls,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
    output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn,
    output logic                     ps_xb_w_bcEn,
    input  logic                     alu_ps_az,
    input  logic                     alu_ps_an,
    input  logic                     alu_ps_ac,
    input  logic                     alu_ps_av,
    input  logic                     alu_ps_compd,
    input  logic                     mul_ps_mv,
    input  logic                     mul_ps_mn,
    input  logic                     shf_ps_sv,
    input  logic                     shf_ps_sz,
    output logic [8:0]               astat
);

    ctrl_t             fe_ctrl;
    ctrl_t             e_ctrl;
    instr_class_e      w_cls;
    logic [ADDR_W-1:0] w_wadd;
    logic              ready_armed;
    logic              hazard;
    logic              accept;

    ps_cu_decode u_decode (
        .instr (fe.fe_instr),
        .ctrl  (fe_ctrl)
    );

    // Only the E slot can conflict: the W-slot write lands in the RF on the same
    // edge that the incoming instruction moves into E and reads.
    assign hazard = fe.fe_valid && (fe_ctrl.cls != CLS_NOP) && (e_ctrl.cls != CLS_NOP)
                    && ((fe_ctrl.raddx == e_ctrl.wadd) || (fe_ctrl.raddy == e_ctrl.wadd));

    assign fe.iss_ready = ready_armed & ~stall & ~hazard;
    assign accept       = fe.fe_valid & fe.iss_ready;

    // Slots advance together; a stall freezes both and a refused or absent
    // instruction enters E as a bubble.
    always_ff @(posedge clk_dcd or negedge reset) begin
        if (!reset) begin
            ready_armed <= 1'b0;
            e_ctrl      <= '0;
            w_cls       <= CLS_NOP;
            w_wadd      <= '0;
        end else begin
            ready_armed <= 1'b1;
            if (!stall) begin
                e_ctrl <= accept ? fe_ctrl : '0;
                w_cls  <= e_ctrl.cls;
                w_wadd <= e_ctrl.wadd;
            end
        end
    end

    // Flags are taken at the end of the W slot and only for the unit that ran.
    always_ff @(posedge clk_dcd or negedge reset) begin
        if (!reset) begin
            astat <= '0;
        end else if (!stall) begin
            case (w_cls)
                CLS_ALU: begin
                    astat[AST_AZ]    <= alu_ps_az;
                    astat[AST_AN]    <= alu_ps_an;
                    astat[AST_AC]    <= alu_ps_ac;
                    astat[AST_AV]    <= alu_ps_av;
                    astat[AST_COMPD] <= alu_ps_compd;
                end
                CLS_MUL: begin
                    astat[AST_MV] <= mul_ps_mv;
                    astat[AST_MN] <= mul_ps_mn;
                end
                CLS_SHF: begin
                    astat[AST_SV] <= shf_ps_sv;
                    astat[AST_SZ] <= shf_ps_sz;
                end
                default: ;
            endcase
        end
    end

    // Enables are masked by the live stall so the held slot contents re-drive
    // in the very first cycle after the stall drops.
    assign ps_alu_en    = ~stall & (e_ctrl.cls == CLS_ALU);
    assign ps_mul_en    = ~stall & (e_ctrl.cls == CLS_MUL);
    assign ps_shf_en    = ~stall & (e_ctrl.cls == CLS_SHF);
    assign ps_xb_w_cuEn = stall ? '0 : src_of(w_cls);
    assign ps_xb_w_bcEn = 1'b0;

    assign ps_alu_log   = e_ctrl.alu_log;
    assign ps_alu_hc    = e_ctrl.alu_hc;
    assign ps_alu_sc    = e_ctrl.alu_sc;
    assign ps_alu_sat   = e_ctrl.alu_sat;
    assign ps_alu_ci    = e_ctrl.alu_ci;
    assign ps_mul_otreg = e_ctrl.mul_otreg;
    assign ps_mul_dtsts = e_ctrl.mul_dtsts;
    assign ps_mul_cls   = e_ctrl.mul_cls;
    assign ps_mul_sc    = e_ctrl.mul_sc;
    assign ps_shf_cls   = e_ctrl.shf_cls;
    assign ps_xb_raddx  = e_ctrl.raddx;
    assign ps_xb_raddy  = e_ctrl.raddy;
    assign ps_xb_wadd   = w_wadd;

endmodule

// File: tb/tb_ps_cu_issue.sv
// Self-checking bench for ps_cu_issue: directed scenarios followed by random
// traffic, all compared against a word-level reference model of the E/W slots.
module tb_ps_cu_issue;

    logic       clk_dcd = 1'b0;
    logic       reset;
    logic       stall;
    logic       ps_alu_en, ps_alu_log, ps_alu_sat, ps_alu_ci;
    logic [1:0] ps_alu_hc;
    logic [2:0] ps_alu_sc;
    logic       ps_mul_en, ps_mul_otreg;
    logic [3:0] ps_mul_dtsts;
    logic [1:0] ps_mul_cls, ps_mul_sc;
    logic       ps_shf_en;
    logic [1:0] ps_shf_cls;
    logic [3:0] ps_xb_raddx, ps_xb_raddy, ps_xb_wadd;
    logic [2:0] ps_xb_w_cuEn;
    logic       ps_xb_w_bcEn;
    logic       alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd;
    logic       mul_ps_mv, mul_ps_mn, shf_ps_sv, shf_ps_sz;
    logic [8:0] astat;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: raw instruction words sitting in E and W (0 = bubble).
    logic [31:0] m_e;
    logic [31:0] m_w;
    logic [8:0]  m_astat;
    bit          m_armed;
    bit          m_accepted;

    ps_cu_issue_if #(.INSTR_WIDTH(32)) fe ();

    ps_cu_issue dut (
        .clk_dcd      (clk_dcd),
        .reset        (reset),
        .stall        (stall),
        .fe           (fe),
        .ps_alu_en    (ps_alu_en),
        .ps_alu_log   (ps_alu_log),
        .ps_alu_sat   (ps_alu_sat),
        .ps_alu_ci    (ps_alu_ci),
        .ps_alu_hc    (ps_alu_hc),
        .ps_alu_sc    (ps_alu_sc),
        .ps_mul_en    (ps_mul_en),
        .ps_mul_otreg (ps_mul_otreg),
        .ps_mul_dtsts (ps_mul_dtsts),
        .ps_mul_cls   (ps_mul_cls),
        .ps_mul_sc    (ps_mul_sc),
        .ps_shf_en    (ps_shf_en),
        .ps_shf_cls   (ps_shf_cls),
        .ps_xb_raddx  (ps_xb_raddx),
        .ps_xb_raddy  (ps_xb_raddy),
        .ps_xb_wadd   (ps_xb_wadd),
        .ps_xb_w_cuEn (ps_xb_w_cuEn),
        .ps_xb_w_bcEn (ps_xb_w_bcEn),
        .alu_ps_az    (alu_ps_az),
        .alu_ps_an    (alu_ps_an),
        .alu_ps_ac    (alu_ps_ac),
        .alu_ps_av    (alu_ps_av),
        .alu_ps_compd (alu_ps_compd),
        .mul_ps_mv    (mul_ps_mv),
        .mul_ps_mn    (mul_ps_mn),
        .shf_ps_sv    (shf_ps_sv),
        .shf_ps_sz    (shf_ps_sz),
        .astat        (astat)
    );

    always #5 clk_dcd = ~clk_dcd;

    function automatic logic [31:0] fld(input logic [31:0] w, input int lo, input int n);
        return (w >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic bit is_hazard(input bit vld, input logic [31:0] instr, input logic [31:0] e);
        logic [31:0] ew;
        ew = fld(e, 26, 4);
        return vld && (fld(instr, 30, 2) != 0) && (fld(e, 30, 2) != 0)
               && ((fld(instr, 22, 4) == ew) || (fld(instr, 18, 4) == ew));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkSlots(input bit stl);
        logic [31:0] ce, cw, a, mu, sh, exp_src;
        ce = fld(m_e, 30, 2);
        cw = fld(m_w, 30, 2);
        a  = (ce == 1) ? 32'd1 : 32'd0;
        mu = (ce == 2) ? 32'd1 : 32'd0;
        sh = (ce == 3) ? 32'd1 : 32'd0;
        exp_src = stl ? 32'd0 : (cw == 1) ? 32'd1 : (cw == 2) ? 32'd4 : (cw == 3) ? 32'd2 : 32'd0;
        checkOutput("alu_en",    32'(ps_alu_en),    stl ? 32'd0 : a);
        checkOutput("mul_en",    32'(ps_mul_en),    stl ? 32'd0 : mu);
        checkOutput("shf_en",    32'(ps_shf_en),    stl ? 32'd0 : sh);
        checkOutput("alu_log",   32'(ps_alu_log),   a  != 0 ? fld(m_e, 17, 1) : 32'd0);
        checkOutput("alu_hc",    32'(ps_alu_hc),    a  != 0 ? fld(m_e, 15, 2) : 32'd0);
        checkOutput("alu_sc",    32'(ps_alu_sc),    a  != 0 ? fld(m_e, 12, 3) : 32'd0);
        checkOutput("alu_sat",   32'(ps_alu_sat),   a  != 0 ? fld(m_e, 11, 1) : 32'd0);
        checkOutput("alu_ci",    32'(ps_alu_ci),    a  != 0 ? fld(m_e, 10, 1) : 32'd0);
        checkOutput("mul_otreg", 32'(ps_mul_otreg), mu != 0 ? fld(m_e, 17, 1) : 32'd0);
        checkOutput("mul_dtsts", 32'(ps_mul_dtsts), mu != 0 ? fld(m_e, 13, 4) : 32'd0);
        checkOutput("mul_cls",   32'(ps_mul_cls),   mu != 0 ? fld(m_e, 11, 2) : 32'd0);
        checkOutput("mul_sc",    32'(ps_mul_sc),    mu != 0 ? fld(m_e, 9, 2)  : 32'd0);
        checkOutput("shf_cls",   32'(ps_shf_cls),   sh != 0 ? fld(m_e, 16, 2) : 32'd0);
        checkOutput("raddx",     32'(ps_xb_raddx),  ce != 0 ? fld(m_e, 22, 4) : 32'd0);
        checkOutput("raddy",     32'(ps_xb_raddy),  ce != 0 ? fld(m_e, 18, 4) : 32'd0);
        checkOutput("wadd",      32'(ps_xb_wadd),   cw != 0 ? fld(m_w, 26, 4) : 32'd0);
        checkOutput("w_cuEn",    32'(ps_xb_w_cuEn), exp_src);
        checkOutput("w_bcEn",    32'(ps_xb_w_bcEn), 32'd0);
        checkOutput("astat",     32'(astat),        32'(m_astat));
    endtask

    // One clock: drive at the falling edge, check 1 ns later, advance the
    // model at the rising edge, return at the next falling edge.
    task automatic applyStimulus(input bit rst_n, input bit stl, input bit vld,
                                 input logic [31:0] instr, input logic [8:0] flags);
        bit          exp_ready;
        logic [31:0] cw;
        logic [8:0]  mask;
        reset       = rst_n;
        stall       = stl;
        fe.fe_valid = vld;
        fe.fe_instr = instr;
        {alu_ps_compd, shf_ps_sz, shf_ps_sv, mul_ps_mn, mul_ps_mv,
         alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az} = flags;
        if (!rst_n) begin
            m_e = '0; m_w = '0; m_astat = '0; m_armed = 0;
        end
        #1;
        exp_ready = m_armed && !stl && !is_hazard(vld, instr, m_e);
        checkOutput("iss_ready", 32'(fe.iss_ready), exp_ready ? 32'd1 : 32'd0);
        checkSlots(stl);
        @(posedge clk_dcd);
        m_accepted = 0;
        if (rst_n) begin
            m_armed    = 1;
            m_accepted = vld && exp_ready;
            if (!stl) begin
                cw   = fld(m_w, 30, 2);
                mask = (cw == 1) ? 9'h10F : (cw == 2) ? 9'h030 : (cw == 3) ? 9'h0C0 : 9'h000;
                m_astat = (m_astat & ~mask) | (flags & mask);
                m_w = m_e;
                m_e = m_accepted ? instr : 32'd0;
            end
        end
        @(negedge clk_dcd);
    endtask

    logic [31:0] r_instr;
    bit          r_vld;
    bit          r_stl;
    bit          r_rst;
    bit          pend;

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        fe.fe_valid = 1'b1;
        fe.fe_instr = 32'h4C48_0000;
        {alu_ps_compd, shf_ps_sz, shf_ps_sv, mul_ps_mn, mul_ps_mv,
         alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az} = '0;
        m_e = '0; m_w = '0; m_astat = '0; m_armed = 0; m_accepted = 0;
        @(negedge clk_dcd);

        // Reset held with a valid instruction offered, then released.
        applyStimulus(0, 0, 1, 32'h4C48_0000, 9'h000);
        applyStimulus(0, 0, 1, 32'h4C48_0000, 9'h1FF);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h000);

        // ALU issue through E and W, az returned during W.
        applyStimulus(1, 0, 1, 32'h4C48_0000, 9'h000);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h000);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h001);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h000);

        // MUL writes r5, ALU reads r5 right behind it: one bubble.
        applyStimulus(1, 0, 1, 32'h9400_0000, 9'h000);
        applyStimulus(1, 0, 1, 32'h4140_0000, 9'h000);
        applyStimulus(1, 0, 1, 32'h4140_0000, 9'h030);
        repeat (3) applyStimulus(1, 0, 0, 32'h0000_0000, 9'h000);

        // r5 write, NOP, read r5: no interlock at W distance.
        applyStimulus(1, 0, 1, 32'h9400_0000, 9'h000);
        applyStimulus(1, 0, 1, 32'h0000_0000, 9'h000);
        applyStimulus(1, 0, 1, 32'h4140_0000, 9'h000);
        repeat (3) applyStimulus(1, 0, 0, 32'h0000_0000, 9'h000);

        // Stall with SHF in E and ALU in W; flags must be ignored meanwhile.
        applyStimulus(1, 0, 1, 32'h4C48_0000, 9'h000);
        applyStimulus(1, 0, 1, 32'hD803_0000, 9'h000);
        repeat (3) applyStimulus(1, 1, 0, 32'h0000_0000, 9'h1FF);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h001);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h080);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h000);

        // Hazard offered during a stall, resolved after the stall clears.
        applyStimulus(1, 0, 1, 32'h9400_0000, 9'h000);
        applyStimulus(1, 1, 1, 32'h4140_0000, 9'h000);
        applyStimulus(1, 0, 1, 32'h4140_0000, 9'h000);
        applyStimulus(1, 0, 1, 32'h4140_0000, 9'h000);

        // Valid toggling every cycle; SHF with sz leaves ALU bits alone.
        applyStimulus(1, 0, 1, 32'h4C48_0000, 9'h081);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h081);
        applyStimulus(1, 0, 1, 32'hD803_0000, 9'h081);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h081);
        applyStimulus(1, 0, 1, 32'h9400_0000, 9'h080);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h080);
        applyStimulus(1, 0, 0, 32'h0000_0000, 9'h000);

        // Reset asserted with instructions in flight.
        applyStimulus(1, 0, 1, 32'h4C48_0000, 9'h000);
        applyStimulus(1, 0, 1, 32'hD803_0000, 9'h000);
        applyStimulus(0, 0, 1, 32'h9400_0000, 9'h1FF);
        applyStimulus(1, 0, 1, 32'h9400_0000, 9'h000);

        // Random traffic, honouring the hold rule on refused instructions.
        pend = 0;
        for (int i = 0; i < 400; i++) begin
            r_stl = ($urandom_range(0, 7) == 0);
            r_rst = ($urandom_range(0, 99) == 0);
            if (!pend) begin
                r_vld   = ($urandom_range(0, 3) != 0);
                r_instr = $urandom;
                r_instr[29:26] = 4'($urandom_range(0, 3));
                r_instr[25:22] = 4'($urandom_range(0, 3));
                r_instr[21:18] = 4'($urandom_range(0, 3));
            end
            applyStimulus(!r_rst, r_stl, r_vld, r_instr, 9'($urandom));
            pend = r_vld && !m_accepted;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
